// File: rtl/edge_sync_pkg.sv
// ============================================================================
// Module      : edge_sync_pkg
// Description : Shared types, parameter limits and helpers for the
//               multi_edge_sync block (edge-mode encoding, qualification,
//               parameter range check).
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package edge_sync_pkg;

  // Per-channel edge selection, two bits per channel on mode_i.
  typedef enum logic [1:0] {
    OFF  = 2'b00,
    RISE = 2'b01,
    FALL = 2'b10,
    BOTH = 2'b11
  } edge_mode_t;

  // Legal parameter ranges.
  localparam int NCH_MIN         = 1;
  localparam int NCH_MAX         = 32;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int CNT_W_MIN       = 2;
  localparam int CNT_W_MAX       = 16;
  localparam int FILT_LEN_MIN    = 2;
  localparam int FILT_LEN_MAX    = 15;

  // True when the detected edge direction is enabled by the channel mode.
  function automatic logic edge_qualifies(input edge_mode_t mode,
                                          input logic       rise,
                                          input logic       fall);
    logic q;
    case (mode)
      RISE:    q = rise;
      FALL:    q = fall;
      BOTH:    q = rise | fall;
      default: q = 1'b0;
    endcase
    return q;
  endfunction

  // True when every parameter lies inside its legal range.
  function automatic bit params_ok(input int nch, input int sync_stages,
                                   input int cnt_w, input int filt_len);
    return (nch >= NCH_MIN) && (nch <= NCH_MAX) &&
           (sync_stages >= SYNC_STAGES_MIN) && (sync_stages <= SYNC_STAGES_MAX) &&
           (cnt_w >= CNT_W_MIN) && (cnt_w <= CNT_W_MAX) &&
           (filt_len >= FILT_LEN_MIN) && (filt_len <= FILT_LEN_MAX);
  endfunction

endpackage

`default_nettype wire

// File: rtl/multi_edge_sync_if.sv
// ============================================================================
// Module      : multi_edge_sync_if
// Description : Channel bus of the multi_edge_sync block.
// Signals     : async_sig [NCH]       asynchronous level inputs
//               mode_i    [2*NCH]     per-channel edge mode (edge_mode_t)
//               clr_i     [NCH]       per-channel clear of pending + counter
//               pulse_o   [NCH]       one-clock pulse per qualifying edge
//               pend_o    [NCH]       sticky pending flags
//               cnt_o     [NCH*CNT_W] saturating counts, channel 0 in LSBs
//               armed_o               high once post-reset hold-off elapsed
// Modports    : slave  - the synchroniser block
//               master - the block's user
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multi_edge_sync_if #(
  parameter int NCH   = 4,
  parameter int CNT_W = 8
);

  logic [NCH-1:0]       async_sig;
  logic [2*NCH-1:0]     mode_i;
  logic [NCH-1:0]       clr_i;
  logic [NCH-1:0]       pulse_o;
  logic [NCH-1:0]       pend_o;
  logic [NCH*CNT_W-1:0] cnt_o;
  logic                 armed_o;

  modport slave (
    input  async_sig, mode_i, clr_i,
    output pulse_o, pend_o, cnt_o, armed_o
  );

  modport master (
    output async_sig, mode_i, clr_i,
    input  pulse_o, pend_o, cnt_o, armed_o
  );

endinterface

`default_nettype wire

// File: rtl/edge_sync_chan.sv
// ============================================================================
// Module      : edge_sync_chan
// Description : One channel: synchroniser chain, optional glitch filter,
//               history flop, edge qualification, registered pulse, sticky
//               pending flag and saturating event counter.
// Ports       : outclk  - destination clock (rising edge)
//               rst_n   - asynchronous active-low reset
//               armed_i - shared hold-off done; low suppresses pulses
//               async_i - asynchronous level input
//               mode_i  - edge mode for this channel
//               clr_i   - synchronous clear of pending flag and counter
//               pulse_o - one-clock pulse per qualifying edge
//               pend_o  - sticky pending flag
//               cnt_o   - saturating event count
// Macro       : EDGE_GLITCH_FILTER_EN - inserts the FILT_LEN glitch filter
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_sync_chan
  import edge_sync_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int FILT_LEN    = 4
) (
  input  wire logic             outclk,
  input  wire logic             rst_n,
  input  wire logic             armed_i,
  input  wire logic             async_i,
  input  wire edge_mode_t       mode_i,
  input  wire logic             clr_i,
  output      logic             pulse_o,
  output      logic             pend_o,
  output      logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_w;
  logic                   lvl_w;
  logic                   hist_q, hist_d;
  logic                   rise_w, fall_w, qual_w;
  logic                   pulse_q;
  logic                   pend_q, pend_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  // Synchroniser chain; bit 0 samples the asynchronous input.
  always_ff @(posedge outclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
    end
  end

  assign last_w = sync_q[SYNC_STAGES-1];

`ifdef EDGE_GLITCH_FILTER_EN
  localparam int FCNT_W = 4;

  logic              filt_q, filt_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  // The filtered level follows the chain only after it has disagreed for
  // FILT_LEN consecutive clocks. During hold-off it tracks the chain
  // directly so a level present at reset release never looks like an edge.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (!armed_i) begin
      filt_d = last_w;
    end else if (last_w != filt_q) begin
      if (fcnt_q == FCNT_W'(FILT_LEN - 1)) begin
        filt_d = last_w;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge outclk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign lvl_w = filt_q;
`else
  assign lvl_w = last_w;
`endif

  // History tracks the chain itself while not armed (same as lvl_w in the
  // unfiltered build), so hold-off ends with history equal to the level.
  assign hist_d = armed_i ? lvl_w : last_w;

  assign rise_w = lvl_w & ~hist_q;
  assign fall_w = ~lvl_w & hist_q;
  assign qual_w = armed_i & edge_qualifies(mode_i, rise_w, fall_w);

  // Pending and counter react to the registered pulse, so a clear sampled
  // while pulse_o is high still records that event (pend=1, cnt=1).
  always_comb begin
    pend_d = pend_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      pend_d = pulse_q;
      cnt_d  = pulse_q ? CNT_W'(1) : '0;
    end else if (pulse_q) begin
      pend_d = 1'b1;
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge outclk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q  <= 1'b0;
      pulse_q <= 1'b0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      hist_q  <= hist_d;
      pulse_q <= qual_w;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pulse_o = pulse_q;
  assign pend_o  = pend_q;
  assign cnt_o   = cnt_q;

endmodule

`default_nettype wire

// File: rtl/multi_edge_sync.sv
// ============================================================================
// Module      : multi_edge_sync
// Description : NCH independent asynchronous-level edge detectors in the
//               outclk domain, each with a SYNC_STAGES synchroniser, edge
//               mode select, registered pulse, sticky pending flag and
//               saturating counter. A shared hold-off counter suppresses
//               pulses for SYNC_STAGES+1 clocks after reset release.
// Ports       : outclk - destination clock (rising edge)
//               rst_n  - asynchronous active-low reset
//               bus    - multi_edge_sync_if.slave (async_sig, mode_i, clr_i,
//                        pulse_o, pend_o, cnt_o, armed_o)
// Macro       : EDGE_GLITCH_FILTER_EN - per-channel glitch filter of
//               FILT_LEN clocks; FILT_LEN is ignored when undefined
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_edge_sync
  import edge_sync_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int FILT_LEN    = 4
) (
  input wire logic        outclk,
  input wire logic        rst_n,
  multi_edge_sync_if.slave bus
);

  // Wide enough to count to SYNC_STAGES_MAX+1.
  localparam int HOLD_W    = 3;
  localparam bit PARAMS_OK = params_ok(NCH, SYNC_STAGES, CNT_W, FILT_LEN);

  // Out-of-range parameters leave this marker scope in the elaborated
  // hierarchy where netlist reports make it easy to spot.
  if (!PARAMS_OK) begin : g_param_range_violation
  end

  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic                 armed_q, armed_d;
  logic [NCH-1:0]       pulse_w;
  logic [NCH-1:0]       pend_w;
  logic [NCH*CNT_W-1:0] cnt_w;

  // Hold-off: armed after SYNC_STAGES+1 clocks, then frozen until reset.
  always_comb begin
    hold_d  = hold_q;
    armed_d = armed_q;
    if (!armed_q) begin
      hold_d = hold_q + 1'b1;
      if (hold_q == HOLD_W'(SYNC_STAGES)) begin
        armed_d = 1'b1;
      end
    end
  end

  always_ff @(posedge outclk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      armed_q <= armed_d;
    end
  end

  for (genvar ch = 0; ch < NCH; ch++) begin : g_chan
    edge_sync_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W),
      .FILT_LEN    (FILT_LEN)
    ) u_chan (
      .outclk  (outclk),
      .rst_n   (rst_n),
      .armed_i (armed_q),
      .async_i (bus.async_sig[ch]),
      .mode_i  (edge_mode_t'(bus.mode_i[2*ch +: 2])),
      .clr_i   (bus.clr_i[ch]),
      .pulse_o (pulse_w[ch]),
      .pend_o  (pend_w[ch]),
      .cnt_o   (cnt_w[ch*CNT_W +: CNT_W])
    );
  end

  assign bus.pulse_o = pulse_w;
  assign bus.pend_o  = pend_w;
  assign bus.cnt_o   = cnt_w;
  assign bus.armed_o = armed_q;

endmodule

`default_nettype wire

// File: tb/tb_multi_edge_sync.sv
// ============================================================================
// Module      : tb_multi_edge_sync
// Description : Directed self-checking bench. Two instances share stimulus:
//               u_dut (NCH=4, SYNC_STAGES=2, CNT_W=8) and u_sat (CNT_W=2)
//               for counter saturation.
// Macro       : EDGE_GLITCH_FILTER_EN - adds the glitch-filter steps and
//               lengthens the expected latency by FILT_LEN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_edge_sync;
  import edge_sync_pkg::*;

  localparam int NCH  = 4;
  localparam int SYNC = 2;
  localparam int FILT = 4;
`ifdef EDGE_GLITCH_FILTER_EN
  localparam int LAT = SYNC + FILT;
`else
  localparam int LAT = SYNC;
`endif
  // Settling window per stimulus step: pulse lands at tick LAT+1.
  localparam int WIN = LAT + 3;

  logic             outclk;
  logic             rst_n;
  logic [NCH-1:0]   async_sig;
  logic [2*NCH-1:0] mode;
  logic [NCH-1:0]   clr;

  int total = 0;
  int bad   = 0;
  int pc [NCH];

  multi_edge_sync_if #(.NCH(NCH), .CNT_W(8)) ifa ();
  multi_edge_sync_if #(.NCH(NCH), .CNT_W(2)) ifb ();

  assign ifa.async_sig = async_sig;
  assign ifa.mode_i    = mode;
  assign ifa.clr_i     = clr;
  assign ifb.async_sig = async_sig;
  assign ifb.mode_i    = mode;
  assign ifb.clr_i     = clr;

  multi_edge_sync #(.NCH(NCH), .SYNC_STAGES(SYNC), .CNT_W(8), .FILT_LEN(FILT))
    u_dut (.outclk(outclk), .rst_n(rst_n), .bus(ifa));

  multi_edge_sync #(.NCH(NCH), .SYNC_STAGES(SYNC), .CNT_W(2), .FILT_LEN(FILT))
    u_sat (.outclk(outclk), .rst_n(rst_n), .bus(ifb));

  initial outclk = 1'b0;
  always #5 outclk = ~outclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge outclk);
    #1;
  endtask

  task automatic clr_pc();
    for (int c = 0; c < NCH; c++) pc[c] = 0;
  endtask

  // Advance n clocks, counting pulse_o cycles per channel on u_dut.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      for (int c = 0; c < NCH; c++) if (ifa.pulse_o[c]) pc[c]++;
    end
  endtask

  initial begin
    // ---- Reset with all inputs high, all modes BOTH ----
    rst_n     = 1'b0;
    async_sig = '1;
    mode      = '1;
    clr       = '0;
    tick();
    tick();
    chk("rst_pulse", 32'(ifa.pulse_o), 32'h0);
    chk("rst_pend",  32'(ifa.pend_o),  32'h0);
    chk("rst_cnt",   ifa.cnt_o,        32'h0);
    chk("rst_armed", 32'(ifa.armed_o), 32'h0);

    rst_n = 1'b1;
    clr_pc();
    run(2);
    chk("holdoff_armed_lo", 32'(ifa.armed_o), 32'h0);
    run(1);
    chk("holdoff_armed_hi", 32'(ifa.armed_o), 32'h1);
    run(WIN);
    chk("high_at_release_pulses", 32'(pc[0] + pc[1] + pc[2] + pc[3]), 32'h0);
    chk("high_at_release_pend", 32'(ifa.pend_o), 32'h0);

    // ---- Clean restart with inputs low ----
    rst_n     = 1'b0;
    async_sig = '0;
    mode      = '0;
    tick();
    rst_n = 1'b1;
    run(4);
    chk("restart_armed", 32'(ifa.armed_o), 32'h1);

    // ---- ch0 RISE: single rising edge ----
    mode[1:0]    = RISE;
    async_sig[0] = 1'b1;
    repeat (LAT) tick();
    chk("ch0_rise_early", 32'(ifa.pulse_o), 32'h0);
    tick();
    chk("ch0_rise_pulse", 32'(ifa.pulse_o), 32'h1);
    tick();
    chk("ch0_rise_width", 32'(ifa.pulse_o), 32'h0);
    chk("ch0_pend", 32'(ifa.pend_o), 32'h1);
    chk("ch0_cnt",  32'(ifa.cnt_o[7:0]), 32'h1);

    // ---- ch0 falling edge is ignored in RISE mode ----
    clr_pc();
    async_sig[0] = 1'b0;
    run(WIN);
    chk("ch0_fall_ignored", 32'(pc[0]), 32'h0);
    chk("ch0_cnt_hold", 32'(ifa.cnt_o[7:0]), 32'h1);

    // ---- ch1 BOTH: three full toggles -> six pulses ----
    mode[3:2] = BOTH;
    clr_pc();
    for (int i = 0; i < 6; i++) begin
      async_sig[1] = ~async_sig[1];
      run(WIN);
    end
    chk("ch1_both_pulses", 32'(pc[1]), 32'h6);
    chk("ch1_both_cnt", 32'(ifa.cnt_o[15:8]), 32'h6);

    // ---- ch1 OFF: toggles produce nothing ----
    mode[3:2] = OFF;
    clr_pc();
    for (int i = 0; i < 2; i++) begin
      async_sig[1] = ~async_sig[1];
      run(WIN);
    end
    chk("ch1_off_pulses", 32'(pc[1]), 32'h0);
    chk("ch1_off_cnt", 32'(ifa.cnt_o[15:8]), 32'h6);

    // ---- Clear ch0 only ----
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    chk("clr0_pend", 32'(ifa.pend_o), 32'h2);
    chk("clr0_cnt", ifa.cnt_o, 32'h0000_0600);

    // ---- ch2 saturation on the 2-bit instance ----
    mode[5:4] = RISE;
    for (int i = 0; i < 5; i++) begin
      async_sig[2] = 1'b1;
      run(WIN);
      async_sig[2] = 1'b0;
      run(WIN);
    end
    chk("sat_cnt2", 32'(ifb.cnt_o[5:4]), 32'h3);
    chk("wide_cnt2", 32'(ifa.cnt_o[23:16]), 32'h5);
    chk("sat_pend2", 32'(ifb.pend_o[2]), 32'h1);

    // ---- Clear in the same clock as a pulse ----
    async_sig[2] = 1'b1;
    repeat (LAT + 1) tick();
    chk("clr_pulse_seen", 32'(ifb.pulse_o), 32'h4);
    clr[2] = 1'b1;
    tick();
    clr[2] = 1'b0;
    chk("clr_pulse_cnt_sat", 32'(ifb.cnt_o[5:4]), 32'h1);
    chk("clr_pulse_pend_sat", 32'(ifb.pend_o[2]), 32'h1);
    chk("clr_pulse_cnt_wide", 32'(ifa.cnt_o[23:16]), 32'h1);

    // ---- ch3 FALL ----
    mode[7:6] = FALL;
    clr_pc();
    async_sig[3] = 1'b1;
    run(WIN);
    chk("ch3_rise_ignored", 32'(pc[3]), 32'h0);
    async_sig[3] = 1'b0;
    repeat (LAT + 1) tick();
    chk("ch3_fall_pulse", 32'(ifa.pulse_o), 32'h8);
    tick();
    chk("ch3_fall_cnt", 32'(ifa.cnt_o[31:24]), 32'h1);

    // ---- Reset one clock after an input edge ----
    async_sig[0] = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_pend", 32'(ifa.pend_o), 32'h0);
    chk("midrst_cnt", ifa.cnt_o, 32'h0);
    chk("midrst_cnt_sat", 32'(ifb.cnt_o), 32'h0);
    chk("midrst_armed", 32'(ifa.armed_o), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    clr_pc();
    run(WIN + 3);
    chk("midrst_no_pulse", 32'(pc[0] + pc[1] + pc[2] + pc[3]), 32'h0);
    chk("midrst_pend_after", 32'(ifa.pend_o), 32'h0);
    chk("midrst_rearmed", 32'(ifa.armed_o), 32'h1);

    // ---- Operation resumes after reset ----
    async_sig[0] = 1'b0;
    run(WIN);
    async_sig[0] = 1'b1;
    repeat (LAT + 1) tick();
    chk("resume_pulse", 32'(ifa.pulse_o), 32'h1);

`ifdef EDGE_GLITCH_FILTER_EN
    // ---- Glitch filter: 3-clock excursion dropped, 6-clock kept ----
    mode[3:2] = RISE;
    clr_pc();
    async_sig[1] = 1'b1;
    repeat (3) tick();
    async_sig[1] = 1'b0;
    run(12);
    chk("filt_glitch", 32'(pc[1]), 32'h0);
    async_sig[1] = 1'b1;
    repeat (6) tick();
    chk("filt_early", 32'(ifa.pulse_o[1]), 32'h0);
    tick();
    chk("filt_pulse", 32'(ifa.pulse_o[1]), 32'h1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
